// File: rtl/logic_unit_pkg.sv
// Op encoding and the bitwise op function shared by the logic unit pipeline and its bench.
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Single-bit form; callers apply it per bit, so it works for any operand width.
  function automatic logic logic_op(op_e op, logic a, logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// LOGIC_UNIT_REDUCE_EN adds the out_red reduction flags.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  op_e              out_op;
  logic [CNT_W-1:0] done_cnt;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic [2:0]       out_red;

  modport master (output in_valid, in_op, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_f, out_op, done_cnt, out_red);
  modport slave  (input  in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_f, out_op, done_cnt, out_red);
`else
  modport master (output in_valid, in_op, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_f, out_op, done_cnt);
  modport slave  (input  in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_f, out_op, done_cnt);
`endif

endinterface

// File: rtl/logic_pipe_stage.sv
// One valid/payload register of the pipeline; loads whenever the stage advances.
module logic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         adv,
  output logic         dn_valid,
  output logic [W-1:0] dn_data
);

  // Payload only loads with a valid item so an empty stage keeps its last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (adv) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined eight-op bitwise unit with valid/ready on both sides and a completion counter.
// Define LOGIC_UNIT_REDUCE_EN to carry {^f, |f, &f} alongside each result as out_red.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

`ifdef LOGIC_UNIT_REDUCE_EN
  localparam int PAY_W = WIDTH + OP_W + 3;
`else
  localparam int PAY_W = WIDTH + OP_W;
`endif

  logic [WIDTH-1:0] f_in;
  logic [PAY_W-1:0] pay [DEPTH+1];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    f_in = '0;
    for (int i = 0; i < WIDTH; i++) f_in[i] = logic_op(bus.in_op, bus.in_a[i], bus.in_b[i]);
  end

`ifdef LOGIC_UNIT_REDUCE_EN
  assign pay[0] = {^f_in, |f_in, &f_in, bus.in_op, f_in};
`else
  assign pay[0] = {bus.in_op, f_in};
`endif

  // A stage advances when it or any stage after it is empty, or the consumer takes the head.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = bus.out_ready;
      for (int j = k; j < DEPTH; j++) if (!vld[j]) adv[k] = 1'b1;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic up_v;
    if (k == 0) begin : g_first
      assign up_v = bus.in_valid;
    end else begin : g_rest
      assign up_v = vld[k-1];
    end
    logic_pipe_stage #(.W(PAY_W)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_v),
      .up_data  (pay[k]),
      .adv      (adv[k]),
      .dn_valid (vld[k]),
      .dn_data  (pay[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (vld[DEPTH-1] && bus.out_ready) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.in_ready  = !rst && adv[0];
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_f     = pay[DEPTH][WIDTH-1:0];
  assign bus.out_op    = op_e'(pay[DEPTH][WIDTH +: OP_W]);
  assign bus.done_cnt  = cnt_q;
`ifdef LOGIC_UNIT_REDUCE_EN
  assign bus.out_red   = pay[DEPTH][WIDTH+OP_W +: 3];
`endif

endmodule
